multi_mode_counter_param: RTL and testbench

//  Parametrised successor of the 4-bit multi-mode up/down counter used by count_if based benches.

---
 rtl/multi_mode_counter_param.sv | 119 +++++++++++
 tb/tb_multi_mode_counter_param.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_counter_param.sv
// Parametrised multi-mode up/down counter with wrap/saturate arithmetic,
// winner/loser event scoring and a gameover restart when a score reaches GAME_LIMIT.
module multi_mode_counter_param #(
   parameter int WIDTH      = 4,
   parameter int SCORE_W    = 4,
   parameter int GAME_LIMIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               INIT,
   input  logic [WIDTH-1:0]   initial_value,
   input  logic               en,
   input  logic               sat,
   input  logic [1:0]         control,
   output logic [WIDTH-1:0]   count,
   output logic               winner,
   output logic               loser,
   output logic [SCORE_W-1:0] win_cnt,
   output logic [SCORE_W-1:0] lose_cnt,
   output logic               gameover,
   output logic [1:0]         who
);

   localparam logic [WIDTH-1:0]   MAX   = '1;
   localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(GAME_LIMIT);
   localparam logic [1:0]         WHO_NONE = 2'b00;
   localparam logic [1:0]         WHO_LOSE = 2'b01;
   localparam logic [1:0]         WHO_WIN  = 2'b10;

   logic [WIDTH:0]     mag;
   logic [WIDTH:0]     up_sum;
   logic [WIDTH:0]     dn_diff;
   logic [WIDTH-1:0]   step_val;

   logic [WIDTH-1:0]   count_d;
   logic               winner_d;
   logic               loser_d;
   logic [SCORE_W-1:0] win_cnt_d;
   logic [SCORE_W-1:0] lose_cnt_d;
   logic               gameover_d;
   logic [1:0]         who_d;

   // One extra bit on each side exposes carry-out (up) or borrow (down) for clamping.
   always_comb begin
      mag     = {{(WIDTH-1){1'b0}}, control[0], ~control[0]};
      up_sum  = {1'b0, count} + mag;
      dn_diff = {1'b0, count} - mag;
      if (!control[1])
         step_val = (sat && up_sum[WIDTH]) ? MAX : up_sum[WIDTH-1:0];
      else
         step_val = (sat && dn_diff[WIDTH]) ? '0 : dn_diff[WIDTH-1:0];
   end

   // NOTE: every next-state signal gets a default first so no path through
   // the if/else chain leaves it unassigned, which would infer a latch.
   always_comb begin
      count_d    = count;
      winner_d   = 1'b0;
      loser_d    = 1'b0;
      win_cnt_d  = win_cnt;
      lose_cnt_d = lose_cnt;
      gameover_d = 1'b0;
      who_d      = who;

      if (clear) begin
         count_d    = '0;
         win_cnt_d  = '0;
         lose_cnt_d = '0;
         who_d      = WHO_NONE;
      end else if (INIT) begin
         count_d = initial_value;
      end else if (en) begin
         count_d  = step_val;
         winner_d = (step_val == MAX);
         loser_d  = (step_val == '0);
         if (winner_d) win_cnt_d  = win_cnt + 1'b1;
         if (loser_d)  lose_cnt_d = lose_cnt + 1'b1;

         // A score reaching the limit ends the game on this same edge; the
         // event flag still shows what happened, but the board restarts.
         if (winner_d && (win_cnt_d == LIMIT)) begin
            gameover_d = 1'b1;
            who_d      = WHO_WIN;
         end else if (loser_d && (lose_cnt_d == LIMIT)) begin
            gameover_d = 1'b1;
            who_d      = WHO_LOSE;
         end
         if (gameover_d) begin
            count_d    = '0;
            win_cnt_d  = '0;
            lose_cnt_d = '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count    <= '0;
         winner   <= 1'b0;
         loser    <= 1'b0;
         win_cnt  <= '0;
         lose_cnt <= '0;
         gameover <= 1'b0;
         who      <= WHO_NONE;
      end else begin
         count    <= count_d;
         winner   <= winner_d;
         loser    <= loser_d;
         win_cnt  <= win_cnt_d;
         lose_cnt <= lose_cnt_d;
         gameover <= gameover_d;
         who      <= who_d;
      end
   end

endmodule

// File: tb/tb_multi_mode_counter_param.sv
// Self-checking bench for multi_mode_counter_param (WIDTH=4, SCORE_W=4, GAME_LIMIT=15):
// a directed vector table plus hand-written gameover and async-reset sequences.
module tb_multi_mode_counter_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic       init;
   logic [3:0] initial_value;
   logic       en;
   logic       sat;
   logic [1:0] control;
   logic [3:0] count;
   logic       winner;
   logic       loser;
   logic [3:0] win_cnt;
   logic [3:0] lose_cnt;
   logic       gameover;
   logic [1:0] who;

   int n_cmp = 0;
   int n_bad = 0;

   multi_mode_counter_param #(.WIDTH(4), .SCORE_W(4), .GAME_LIMIT(15)) dut (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear),
      .INIT          (init),
      .initial_value (initial_value),
      .en            (en),
      .sat           (sat),
      .control       (control),
      .count         (count),
      .winner        (winner),
      .loser         (loser),
      .win_cnt       (win_cnt),
      .lose_cnt      (lose_cnt),
      .gameover      (gameover),
      .who           (who)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       clr;
      logic       ini;
      logic [3:0] ival;
      logic       en;
      logic       sat;
      logic [1:0] ctl;
      logic [3:0] e_count;
      logic       e_win;
      logic       e_lose;
      logic [3:0] e_wc;
      logic [3:0] e_lc;
      logic       e_go;
      logic [1:0] e_who;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs [NVEC];

   function automatic vec_t v(input int clr, input int ini, input int ival, input int e,
                              input int s, input int ctl, input int c, input int w,
                              input int l, input int wc, input int lc, input int go,
                              input int wh);
      vec_t r;
      r.clr = clr[0];    r.ini = ini[0];    r.ival = ival[3:0];
      r.en = e[0];       r.sat = s[0];      r.ctl = ctl[1:0];
      r.e_count = c[3:0]; r.e_win = w[0];   r.e_lose = l[0];
      r.e_wc = wc[3:0];  r.e_lc = lc[3:0];  r.e_go = go[0];
      r.e_who = wh[1:0];
      return r;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int c, input int w, input int l,
                            input int wc, input int lc, input int go, input int wh);
      check({tag, " count"},    int'(count),    c);
      check({tag, " winner"},   int'(winner),   w);
      check({tag, " loser"},    int'(loser),    l);
      check({tag, " win_cnt"},  int'(win_cnt),  wc);
      check({tag, " lose_cnt"}, int'(lose_cnt), lc);
      check({tag, " gameover"}, int'(gameover), go);
      check({tag, " who"},      int'(who),      wh);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic i, input logic [3:0] iv,
                        input logic e, input logic s, input logic [1:0] ct);
      clear = c; init = i; initial_value = iv; en = e; sat = s; control = ct;
   endtask

   initial begin
      //             clr ini ival en sat ctl  cnt w l wc lc go who
      vecs[0]  = v(1, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
      vecs[1]  = v(0, 1, 9,  0, 0, 0,  9,  0, 0, 0, 0, 0, 0);
      vecs[2]  = v(0, 0, 0,  1, 0, 0,  10, 0, 0, 0, 0, 0, 0);
      vecs[3]  = v(0, 0, 0,  1, 0, 0,  11, 0, 0, 0, 0, 0, 0);
      vecs[4]  = v(0, 0, 0,  1, 0, 0,  12, 0, 0, 0, 0, 0, 0);
      vecs[5]  = v(0, 1, 14, 0, 0, 0,  14, 0, 0, 0, 0, 0, 0);
      vecs[6]  = v(0, 0, 0,  1, 0, 1,  0,  0, 1, 0, 1, 0, 0);
      vecs[7]  = v(0, 0, 0,  1, 0, 1,  2,  0, 0, 0, 1, 0, 0);
      vecs[8]  = v(0, 1, 14, 0, 1, 0,  14, 0, 0, 0, 1, 0, 0);
      vecs[9]  = v(0, 0, 0,  1, 1, 1,  15, 1, 0, 1, 1, 0, 0);
      vecs[10] = v(0, 0, 0,  1, 1, 1,  15, 1, 0, 2, 1, 0, 0);
      vecs[11] = v(0, 1, 1,  0, 1, 0,  1,  0, 0, 2, 1, 0, 0);
      vecs[12] = v(0, 0, 0,  1, 1, 3,  0,  0, 1, 2, 2, 0, 0);
      vecs[13] = v(0, 1, 1,  0, 0, 0,  1,  0, 0, 2, 2, 0, 0);
      vecs[14] = v(0, 0, 0,  1, 0, 3,  15, 1, 0, 3, 2, 0, 0);
      vecs[15] = v(0, 0, 0,  1, 0, 2,  14, 0, 0, 3, 2, 0, 0);
      vecs[16] = v(1, 1, 7,  1, 0, 0,  0,  0, 0, 0, 0, 0, 0);
      vecs[17] = v(0, 1, 5,  1, 0, 0,  5,  0, 0, 0, 0, 0, 0);
      vecs[18] = v(0, 0, 0,  0, 0, 0,  5,  0, 0, 0, 0, 0, 0);
      vecs[19] = v(0, 1, 14, 0, 0, 0,  14, 0, 0, 0, 0, 0, 0);
      vecs[20] = v(0, 0, 0,  1, 0, 0,  15, 1, 0, 1, 0, 0, 0);
      vecs[21] = v(0, 0, 0,  0, 0, 0,  15, 0, 0, 1, 0, 0, 0);
      vecs[22] = v(0, 1, 0,  0, 1, 0,  0,  0, 0, 1, 0, 0, 0);
      vecs[23] = v(0, 0, 0,  1, 1, 2,  0,  0, 1, 1, 1, 0, 0);

      // Power-on reset: outputs must be zero while rst is low.
      rst = 1'b0;
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
      #2;
      check_all("por_async", 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_all("por_hold", 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].clr, vecs[i].ini, vecs[i].ival, vecs[i].en, vecs[i].sat, vecs[i].ctl);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_win, vecs[i].e_lose,
                   vecs[i].e_wc, vecs[i].e_lc, vecs[i].e_go, vecs[i].e_who);
      end

      // Winner game: saturate at 15 with +1 for 15 steps; the 15th ends the game.
      drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
      tick();
      drive(1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 2'b00);
      tick();
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'b00);
      for (int k = 1; k <= 14; k++) begin
         tick();
         check_all($sformatf("win_step%0d", k), 15, 1, 0, k, 0, 0, 0);
      end
      tick();
      check_all("win_gameover", 0, 1, 0, 0, 0, 1, 2);
      tick();
      check_all("win_after", 1, 0, 0, 0, 0, 0, 2);

      // Loser game: INIT 1 then -1 gives a loser event each pair; who holds 10 until the end.
      for (int k = 1; k <= 15; k++) begin
         drive(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'b10);
         tick();
         drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b10);
         tick();
         if (k < 15) begin
            check_all($sformatf("lose_step%0d", k), 0, 0, 1, 0, k, 0, 2);
         end
      end
      check_all("lose_gameover", 0, 0, 1, 0, 0, 1, 1);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00);
      tick();
      check_all("lose_after", 0, 0, 0, 0, 0, 0, 1);

      // Asynchronous reset mid-run at count 7, dropped between edges.
      drive(1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 2'b00);
      tick();
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b00);
      tick();
      check("rst_pre count", int'(count), 7);
      #3;
      rst = 1'b0;
      #1;
      check_all("rst_async", 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      check_all("rst_hold", 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      check_all("rst_release", 1, 0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
